// File: rtl/hr_node_multi.sv
// hr_node_multi: multi-channel hierarchical-ring stop. Each channel has a
// one-cycle ring pipeline register, local ejection and a small injection FIFO
// that fills free ring slots. Ring traffic always wins over injection.
module hr_node_multi #(
  parameter int unsigned          ADDR_W    = 4,
  parameter logic [ADDR_W-1:0]    ADDR      = 4'b0010,
  parameter int unsigned          FLIT_W    = 144,
  parameter int unsigned          CH        = 2,
  parameter int unsigned          INJ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*FLIT_W-1:0]   port_i,
  output logic [CH*FLIT_W-1:0]   port_o,
  input  logic [CH*FLIT_W-1:0]   port_local_i,
  output logic [CH*FLIT_W-1:0]   port_local_o,
  output logic [CH-1:0]          portl_ack
);

  localparam int unsigned PTR_W = $clog2(INJ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [FLIT_W-1:0] in_flit;
    logic [FLIT_W-1:0] loc_flit;
    logic [FLIT_W-1:0] mem_q [INJ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLIT_W-1:0] ring_q, ring_d;
    logic [FLIT_W-1:0] ej_q, ej_d;
    logic              eject, pass, empty, full, push, pop;

    assign in_flit  = port_i[c*FLIT_W +: FLIT_W];
    assign loc_flit = port_local_i[c*FLIT_W +: FLIT_W];

    // Slot arbitration, FIFO control and next-state of the output registers
    always_comb begin
      eject    = 1'b0;
      pass     = 1'b0;
      empty    = 1'b0;
      full     = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      ring_d   = '0;
      ej_d     = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      eject = in_flit[0] && (in_flit[ADDR_W:1] == ADDR);
      pass  = in_flit[0] && !eject;
      empty = (cnt_q == '0);
      full  = (cnt_q == CNT_W'(INJ_DEPTH));
      // Full blocks accept even when a pop happens this cycle
      push  = loc_flit[0] && !full;
      pop   = !pass && !empty;

      if (pass) begin
        ring_d = in_flit;
      end else if (pop) begin
        ring_d = mem_q[rd_ptr_q];
      end
      if (eject) begin
        ej_d = in_flit;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Output flit registers and FIFO bookkeeping, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ring_q   <= '0;
        ej_q     <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        ring_q   <= ring_d;
        ej_q     <= ej_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // FIFO storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= loc_flit;
      end
    end

    assign port_o[c*FLIT_W +: FLIT_W]       = ring_q;
    assign port_local_o[c*FLIT_W +: FLIT_W] = ej_q;
    assign portl_ack[c]                     = push;
  end

endmodule

// File: tb/tb_hr_node_multi.sv
// Directed self-checking bench for hr_node_multi (default parameters).
module tb_hr_node_multi;

  localparam int FW = 144;
  localparam int CH = 2;

  logic              clk;
  logic              rst;
  logic [CH*FW-1:0]  port_i;
  logic [CH*FW-1:0]  port_o;
  logic [CH*FW-1:0]  port_local_i;
  logic [CH*FW-1:0]  port_local_o;
  logic [CH-1:0]     portl_ack;

  int n_cmp = 0;
  int n_mis = 0;

  hr_node_multi dut (
    .clk          (clk),
    .rst          (rst),
    .port_i       (port_i),
    .port_o       (port_o),
    .port_local_i (port_local_i),
    .port_local_o (port_local_o),
    .portl_ack    (portl_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] mk(input logic [3:0] dst, input logic [31:0] pl);
    logic [FW-1:0] f;
    f          = '0;
    f[0]       = 1'b1;
    f[4:1]     = dst;
    f[36:5]    = pl;
    f[143:112] = ~pl;
    return f;
  endfunction

  function automatic logic [FW-1:0] sl(input logic [CH*FW-1:0] v, input int c);
    return v[c*FW +: FW];
  endfunction

  function automatic logic [CH*FW-1:0] rand_vec();
    logic [CH*FW-1:0] v;
    for (int i = 0; i < CH*FW; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ring(input int c, input logic [FW-1:0] f);
    port_i[c*FW +: FW] = f;
  endtask

  task automatic set_loc(input int c, input logic [FW-1:0] f);
    port_local_i[c*FW +: FW] = f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      port_i       = rand_vec();
      port_local_i = rand_vec();
      tick();
      n_cmp++;
      if (port_o !== '0) begin
        n_mis++;
        $display("FAIL reset_port_o cyc%0d: got %h want 0", i, port_o);
      end
      n_cmp++;
      if (port_local_o !== '0) begin
        n_mis++;
        $display("FAIL reset_local_o cyc%0d: got %h want 0", i, port_local_o);
      end
    end
    port_i       = '0;
    port_local_i = '0;
    rst          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (port_o !== '0 || port_local_o !== '0 || portl_ack !== 2'b00) begin
        n_mis++;
        $display("FAIL post_reset_idle cyc%0d: port_o=%h local_o=%h ack=%b want all 0",
                 i, port_o, port_local_o, portl_ack);
      end
    end
  endtask

  task automatic test_pass();
    logic [FW-1:0] f;
    f = mk(4'h5, 32'hA5A5_0001);
    set_ring(0, f);
    tick();
    set_ring(0, '0);
    n_cmp++;
    if (sl(port_o, 0) !== f) begin
      n_mis++;
      $display("FAIL pass_ch0: got %h want %h", sl(port_o, 0), f);
    end
    n_cmp++;
    if (port_local_o !== '0 || sl(port_o, 1) !== '0) begin
      n_mis++;
      $display("FAIL pass_side: local_o=%h port_o1=%h want 0", port_local_o, sl(port_o, 1));
    end
    tick();
    n_cmp++;
    if (port_o !== '0) begin
      n_mis++;
      $display("FAIL pass_drain: got %h want 0", port_o);
    end
  endtask

  task automatic test_eject();
    logic [FW-1:0] f;
    f = mk(4'h2, 32'hBEEF_0002);
    set_ring(1, f);
    tick();
    set_ring(1, '0);
    n_cmp++;
    if (sl(port_local_o, 1) !== f) begin
      n_mis++;
      $display("FAIL eject_ch1: got %h want %h", sl(port_local_o, 1), f);
    end
    n_cmp++;
    if (port_o !== '0 || sl(port_local_o, 0) !== '0) begin
      n_mis++;
      $display("FAIL eject_side: port_o=%h local_o0=%h want 0", port_o, sl(port_local_o, 0));
    end
  endtask

  task automatic test_inject();
    logic [FW-1:0] f;
    f = mk(4'h7, 32'hC0DE_0003);
    set_loc(0, f);
    #1;
    n_cmp++;
    if (portl_ack !== 2'b01) begin
      n_mis++;
      $display("FAIL inject_ack: got %b want 01", portl_ack);
    end
    tick();
    set_loc(0, '0);
    n_cmp++;
    if (sl(port_o, 0) !== '0) begin
      n_mis++;
      $display("FAIL inject_no_bypass: got %h want 0", sl(port_o, 0));
    end
    tick();
    n_cmp++;
    if (sl(port_o, 0) !== f) begin
      n_mis++;
      $display("FAIL inject_out: got %h want %h", sl(port_o, 0), f);
    end
    tick();
    n_cmp++;
    if (port_o !== '0) begin
      n_mis++;
      $display("FAIL inject_once: got %h want 0", port_o);
    end
  endtask

  // Eject and inject on one channel in the same cycle; self-addressed local flit rides the ring
  task automatic test_eject_inject();
    logic [FW-1:0] l, e;
    l = mk(4'h2, 32'h5E1F_0004);
    e = mk(4'h2, 32'hE1EC_0005);
    set_loc(1, l);
    tick();
    set_loc(1, '0);
    set_ring(1, e);
    tick();
    set_ring(1, '0);
    n_cmp++;
    if (sl(port_local_o, 1) !== e) begin
      n_mis++;
      $display("FAIL ej_inj_local: got %h want %h", sl(port_local_o, 1), e);
    end
    n_cmp++;
    if (sl(port_o, 1) !== l) begin
      n_mis++;
      $display("FAIL ej_inj_ring: got %h want %h", sl(port_o, 1), l);
    end
    tick();
    n_cmp++;
    if (port_o !== '0 || port_local_o !== '0) begin
      n_mis++;
      $display("FAIL ej_inj_drain: port_o=%h local_o=%h want 0", port_o, port_local_o);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] lf [5];
    logic [FW-1:0] pf;
    for (int i = 0; i < 5; i++) lf[i] = mk(4'h9, 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      pf = mk(4'h5, 32'h2000_0000 + 32'(i));
      set_ring(0, pf);
      set_loc(0, lf[i]);
      #1;
      n_cmp++;
      if (portl_ack[0] !== (i < 4)) begin
        n_mis++;
        $display("FAIL bp_ack%0d: got %b want %b", i, portl_ack[0], (i < 4));
      end
      tick();
      n_cmp++;
      if (sl(port_o, 0) !== pf) begin
        n_mis++;
        $display("FAIL bp_pass%0d: got %h want %h", i, sl(port_o, 0), pf);
      end
    end
    set_ring(0, '0);
    set_loc(0, lf[4]);
    #1;
    n_cmp++;
    if (portl_ack[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_full_with_pop: got %b want 0", portl_ack[0]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      set_loc(0, '0);
      n_cmp++;
      if (sl(port_o, 0) !== lf[i]) begin
        n_mis++;
        $display("FAIL bp_drain%0d: got %h want %h", i, sl(port_o, 0), lf[i]);
      end
    end
    set_loc(0, lf[4]);
    #1;
    n_cmp++;
    if (portl_ack[0] !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_ack_again: got %b want 1", portl_ack[0]);
    end
    tick();
    set_loc(0, '0);
    tick();
    n_cmp++;
    if (sl(port_o, 0) !== lf[4]) begin
      n_mis++;
      $display("FAIL bp_last: got %h want %h", sl(port_o, 0), lf[4]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] pf;
    pf = mk(4'h5, 32'h3000_0000);
    set_ring(0, pf);
    for (int i = 0; i < 3; i++) begin
      set_loc(0, mk(4'hA, 32'h4000_0000 + 32'(i)));
      tick();
    end
    set_loc(0, '0);
    n_cmp++;
    if (sl(port_o, 0) !== pf) begin
      n_mis++;
      $display("FAIL mid_pre: got %h want %h", sl(port_o, 0), pf);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (port_o !== '0 || port_local_o !== '0) begin
      n_mis++;
      $display("FAIL mid_async_clear: port_o=%h local_o=%h want 0", port_o, port_local_o);
    end
    port_i = '0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (port_o !== '0) begin
        n_mis++;
        $display("FAIL mid_stale%0d: got %h want 0", i, port_o);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    port_i       = '0;
    port_local_i = '0;
    test_reset();
    test_pass();
    test_eject();
    test_inject();
    test_eject_inject();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
